priority_serializer: RTL and testbench

Parametrised sequential successor to the combinational 8-to-3 priority encoder. Accepts a WIDTH-bit request vector with a valid/ready handshake. Emits the index of every set bit, one per accepted beat, in priority order (LSB-first or MSB-first). Used wherever a multi-hot request or status vector must be drained into a stream of binary indices: interrupt and event dispatch, arbiter grant logging.

---
 rtl/priority_serializer.sv | 127 ++++++++++++
 tb/tb_priority_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_serializer.sv
// priority_serializer: accepts a WIDTH-bit request vector and drains it as a
// stream of set-bit indices, one per accepted beat, lowest-first or
// highest-first depending on MSB_FIRST.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_ready is high only in IDLE, and in_ready does not
// depend on in_valid. Output side: out_valid is high in DRAIN, and out_valid
// does not depend on out_ready. While valid is high and ready is low, all
// output fields hold.
module priority_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IDX_W:0]   out_count,
    output logic             none,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [IDX_W:0]     out_count_q, out_count_d;
    logic               none_q, none_d;

    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W:0]     in_count;
    logic               one_left;

    // Pick the highest-priority pending bit; looks only at the pending register.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending_q[i]) sel_idx = IDX_W'(i);
            end
        end
    end

    // Popcount of the incoming vector, captured on acceptance.
    always_comb begin
        in_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_count = in_count + (IDX_W+1)'(in_data[i]);
        end
    end

    // Exactly one bit left means the current beat is the final one.
    always_comb begin
        one_left = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    end

    // Next-state logic: accept in IDLE, clear one bit per transferred beat in DRAIN.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_count_d = out_count_q;
        none_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    out_count_d = in_count;
                    if (in_data != '0) begin
                        pending_d = in_data;
                        state_d   = DRAIN;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(WIDTH'(1) << sel_idx);
                    if (one_left) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State registers; reset discards any vector in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_count_q <= '0;
            none_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_count_q <= out_count_d;
            none_q      <= none_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DRAIN);
        out_idx   = sel_idx;
        out_last  = one_left;
        out_count = out_count_q;
        none      = none_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_priority_serializer.sv
// Bench for priority_serializer: four instances (8-bit LSB-first, 8-bit
// MSB-first, 16-bit LSB-first, 5-bit LSB-first) share clock and reset; a
// selector routes the stimulus to one instance at a time and muxes its
// outputs back for checking against a set-bit-list reference model.
module tb_priority_serializer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- shared stimulus / observed outputs ----------------
    logic [15:0] in_data;
    logic        in_valid;
    logic        out_ready;
    int          sel;

    logic        o_in_ready, o_valid, o_last, o_none;
    logic [3:0]  o_idx;
    logic [4:0]  o_count;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

    // ---------------- instances ----------------
    logic [7:0]  d0_data, d1_data;
    logic [15:0] d2_data;
    logic [4:0]  d3_data;
    logic        d0_iv, d1_iv, d2_iv, d3_iv;
    logic        d0_ir, d1_ir, d2_ir, d3_ir;
    logic        d0_ov, d1_ov, d2_ov, d3_ov;
    logic        d0_ol, d1_ol, d2_ol, d3_ol;
    logic        d0_nn, d1_nn, d2_nn, d3_nn;
    logic        d0_st, d1_st, d2_st, d3_st;
    logic [2:0]  d0_idx, d1_idx, d3_idx;
    logic [3:0]  d2_idx;
    logic [3:0]  d0_cnt, d1_cnt, d3_cnt;
    logic [4:0]  d2_cnt;

    always_comb begin
        d0_data = (sel == 0) ? in_data[7:0] : '0;
        d1_data = (sel == 1) ? in_data[7:0] : '0;
        d2_data = (sel == 2) ? in_data : '0;
        d3_data = (sel == 3) ? in_data[4:0] : '0;
        d0_iv   = in_valid && (sel == 0);
        d1_iv   = in_valid && (sel == 1);
        d2_iv   = in_valid && (sel == 2);
        d3_iv   = in_valid && (sel == 3);
    end

    always_comb begin
        o_in_ready = d0_ir; o_valid = d0_ov; o_last = d0_ol; o_none = d0_nn;
        o_idx = 4'(d0_idx); o_count = 5'(d0_cnt);
        case (sel)
            1: begin
                o_in_ready = d1_ir; o_valid = d1_ov; o_last = d1_ol; o_none = d1_nn;
                o_idx = 4'(d1_idx); o_count = 5'(d1_cnt);
            end
            2: begin
                o_in_ready = d2_ir; o_valid = d2_ov; o_last = d2_ol; o_none = d2_nn;
                o_idx = d2_idx; o_count = d2_cnt;
            end
            3: begin
                o_in_ready = d3_ir; o_valid = d3_ov; o_last = d3_ol; o_none = d3_nn;
                o_idx = 4'(d3_idx); o_count = 5'(d3_cnt);
            end
            default: ;
        endcase
    end

    priority_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_d0 (
        .clk(clk), .rst(rst), .in_data(d0_data), .in_valid(d0_iv), .in_ready(d0_ir),
        .out_idx(d0_idx), .out_valid(d0_ov), .out_ready(out_ready), .out_last(d0_ol),
        .out_count(d0_cnt), .none(d0_nn), .state_dbg(d0_st));
    priority_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .in_data(d1_data), .in_valid(d1_iv), .in_ready(d1_ir),
        .out_idx(d1_idx), .out_valid(d1_ov), .out_ready(out_ready), .out_last(d1_ol),
        .out_count(d1_cnt), .none(d1_nn), .state_dbg(d1_st));
    priority_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .in_data(d2_data), .in_valid(d2_iv), .in_ready(d2_ir),
        .out_idx(d2_idx), .out_valid(d2_ov), .out_ready(out_ready), .out_last(d2_ol),
        .out_count(d2_cnt), .none(d2_nn), .state_dbg(d2_st));
    priority_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) u_d3 (
        .clk(clk), .rst(rst), .in_data(d3_data), .in_valid(d3_iv), .in_ready(d3_ir),
        .out_idx(d3_idx), .out_valid(d3_ov), .out_ready(out_ready), .out_last(d3_ol),
        .out_count(d3_cnt), .none(d3_nn), .state_dbg(d3_st));

    // ---------------- reference model ----------------
    // Expected beats: positions of set bits, ascending, or descending when msb.
    task automatic build_expected(input logic [15:0] vec, input int w, input bit msb);
        exp_q.delete();
        for (int i = 0; i < w; i++) begin
            if (vec[i]) begin
                if (msb) exp_q.push_front(4'(i));
                else     exp_q.push_back(4'(i));
            end
        end
    endtask

    // ---------------- scenario driver ----------------
    // mode 0: always ready, 1: fixed pattern 1,0,0,1,1,0,1, 2: random ready.
    // hold: leave in_valid high (same vector) through the drain.
    task automatic drain_and_check(input logic [15:0] vec, input int w, input bit msb,
                                   input int mode, input bit hold, input string name);
        int  exp_cnt;
        int  cycles;
        bit  r;
        bit  pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        build_expected(vec, w, msb);
        exp_cnt = exp_q.size();
        @(negedge clk);
        total++;
        if (o_in_ready !== 1'b1)
            begin bad++; $display("FAIL %s pre_ready: in_ready=%b want 1", name, o_in_ready); end
        in_data  = vec;
        in_valid = 1'b1;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        if (exp_cnt == 0) begin
            total++;
            if (o_none !== 1'b1 || o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_count !== 5'd0)
                begin bad++; $display("FAIL %s zero_accept: none=%b valid=%b in_ready=%b count=%0d want 1 0 1 0",
                    name, o_none, o_valid, o_in_ready, o_count); end
            @(negedge clk);
            total++;
            if (o_none !== 1'b0 || o_valid !== 1'b0 || o_in_ready !== 1'b1)
                begin bad++; $display("FAIL %s zero_after: none=%b valid=%b in_ready=%b want 0 0 1",
                    name, o_none, o_valid, o_in_ready); end
            in_valid = 1'b0;
            return;
        end
        total++;
        if (o_none !== 1'b0)
            begin bad++; $display("FAIL %s none_nonzero: none=%b want 0", name, o_none); end
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[cycles % 7];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            total++;
            if (o_valid !== 1'b1 || o_idx !== exp_q[0] || o_last !== (exp_q.size() == 1) ||
                o_count !== 5'(exp_cnt) || o_in_ready !== 1'b0)
                begin bad++; $display("FAIL %s beat%0d: valid=%b idx=%0d last=%b count=%0d in_ready=%b, want 1 idx=%0d last=%b count=%0d in_ready=0",
                    name, cycles, o_valid, o_idx, o_last, o_count, o_in_ready,
                    exp_q[0], (exp_q.size() == 1), exp_cnt); end
            if (r) void'(exp_q.pop_front());
            cycles++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL %s timeout: %0d beats outstanding want 0", name, exp_q.size());
        end
        if (mode == 0) begin
            total++;
            if (cycles != exp_cnt)
                begin bad++; $display("FAIL %s throughput: cycles=%0d want %0d", name, cycles, exp_cnt); end
        end
        total++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_count !== 5'(exp_cnt) || o_last !== 1'b0)
            begin bad++; $display("FAIL %s end: valid=%b in_ready=%b count=%0d last=%b want 0 1 %0d 0",
                name, o_valid, o_in_ready, o_count, o_last, exp_cnt); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            total++;
            if (o_in_ready !== 1'b1 || o_valid !== 1'b0 || o_last !== 1'b0 || o_idx !== 4'd0 ||
                o_count !== 5'd0 || o_none !== 1'b0)
                begin bad++; $display("FAIL reset_dut%0d: ir=%b v=%b l=%b idx=%0d cnt=%0d none=%b want 1 0 0 0 0 0",
                    s, o_in_ready, o_valid, o_last, o_idx, o_count, o_none); end
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_bit();
        sel = 0;
        drain_and_check(16'h0001, 8, 1'b0, 0, 1'b0, "single_lsb");
        drain_and_check(16'h0080, 8, 1'b0, 0, 1'b0, "single_msb");
    endtask

    task automatic test_multi_bit();
        sel = 0;
        drain_and_check(16'h00F0, 8, 1'b0, 0, 1'b0, "multi_f0");
    endtask

    task automatic test_msb_backpressure();
        sel = 1;
        drain_and_check(16'h00F0, 8, 1'b1, 0, 1'b0, "msb_f0");
        drain_and_check(16'h00F0, 8, 1'b1, 1, 1'b0, "msb_bp");
    endtask

    task automatic test_zero_vector();
        sel = 0;
        drain_and_check(16'h0000, 8, 1'b0, 0, 1'b0, "zero");
        drain_and_check(16'h0055, 8, 1'b0, 0, 1'b0, "after_zero_55");
    endtask

    task automatic test_wide_and_async_reset();
        sel = 2;
        drain_and_check(16'hFFFF, 16, 1'b0, 0, 1'b0, "wide_ffff");
        @(negedge clk);
        in_data = 16'hFFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (o_valid !== 1'b1 || o_idx !== 4'(k))
                begin bad++; $display("FAIL rst_pre_beat%0d: valid=%b idx=%0d want 1 %0d", k, o_valid, o_idx, k); end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_count !== 5'd0 || o_idx !== 4'd0 || o_last !== 1'b0)
            begin bad++; $display("FAIL async_rst: valid=%b in_ready=%b count=%0d idx=%0d last=%b want 0 1 0 0 0",
                o_valid, o_in_ready, o_count, o_idx, o_last); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (o_valid !== 1'b0 || o_in_ready !== 1'b1)
                begin bad++; $display("FAIL post_rst%0d: valid=%b in_ready=%b want 0 1", k, o_valid, o_in_ready); end
        end
    endtask

    task automatic test_non_pow2_hold();
        sel = 3;
        drain_and_check(16'h0011, 5, 1'b0, 0, 1'b1, "w5_hold");
        // in_valid still high: acceptance happens at the edge after the last beat.
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (o_valid !== 1'b1 || o_idx !== 4'd0 || o_count !== 5'd2 || o_last !== 1'b0)
            begin bad++; $display("FAIL w5_reaccept: valid=%b idx=%0d count=%0d last=%b want 1 0 2 0",
                o_valid, o_idx, o_count, o_last); end
        @(negedge clk);
        total++;
        if (o_valid !== 1'b1 || o_idx !== 4'd4 || o_last !== 1'b1)
            begin bad++; $display("FAIL w5_second: valid=%b idx=%0d last=%b want 1 4 1", o_valid, o_idx, o_last); end
        @(negedge clk);
        total++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1)
            begin bad++; $display("FAIL w5_done: valid=%b in_ready=%b want 0 1", o_valid, o_in_ready); end
    endtask

    task automatic test_random();
        int          w;
        bit          msb;
        logic [15:0] mask, vec;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            w   = (sel == 2) ? 16 : (sel == 3) ? 5 : 8;
            msb = (sel == 1);
            mask = 16'((32'd1 << w) - 1);
            vec  = ($urandom_range(0, 7) == 0) ? 16'h0000 : (16'($urandom) & mask);
            drain_and_check(vec, w, msb, 2, 1'b0, "random");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_bit();
        test_multi_bit();
        test_msb_backpressure();
        test_zero_vector();
        test_wide_and_async_reset();
        test_non_pow2_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
